// File: rtl/cpu_input_sequencer.sv
// Board front end for the cpu: synchronizes and debounces keys, assembles the
// instruction word from switch bytes, and sequences load/start/run step enables.
module cpu_input_sequencer #(
  parameter int DB_CYCLES = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  key_n,
  input  logic [9:0]  sw,
  output logic [15:0] ir,
  output logic [7:0]  ir_view,
  output logic        cpu_step,
  output logic        cpu_load,
  output logic        cpu_s,
  input  logic        cpu_w,
  output logic        busy,
  output logic        err
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]  RUN_LIMIT = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, START, RUN} state_e;

  logic [3:0]           key_meta_q, key_sync_q;
  logic [9:0]           sw_meta_q, sw_sync_q;
  logic [3:0]           key_stable_q, key_stable_d;
  logic [3:0][DBW-1:0]  db_cnt_q, db_cnt_d;
  logic [3:0]           press_q, press_d;
  logic [15:0]          ir_q, ir_d;
  state_e               state_q, state_d;
  logic                 step_q, step_d;
  logic                 load_q, load_d;
  logic                 s_q, s_d;
  logic [TW-1:0]        run_cnt_q, run_cnt_d, run_cnt_nxt;
  logic                 err_q, err_d;
  logic                 sw8_unused;

  // sw[8] has no function on this board.
  assign sw8_unused = sw_sync_q[8];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise a latch is inferred.
  always_comb begin
    key_stable_d = key_stable_q;
    db_cnt_d     = db_cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (key_sync_q[k] == key_stable_q[k]) begin
        db_cnt_d[k] = '0;
      end else if (db_cnt_q[k] == DB_LAST) begin
        key_stable_d[k] = key_sync_q[k];
        db_cnt_d[k]     = '0;
      end else begin
        db_cnt_d[k] = db_cnt_q[k] + 1'b1;
      end
    end
    // Only the released->pressed transition of the stable level is an event.
    press_d = key_stable_q & ~key_stable_d;
  end

  always_comb begin
    state_d     = state_q;
    step_d      = 1'b0;
    load_d      = 1'b0;
    s_d         = 1'b0;
    run_cnt_d   = run_cnt_q;
    run_cnt_nxt = run_cnt_q + 1'b1;
    err_d       = err_q;
    ir_d        = ir_q;
    if (state_q != IDLE && press_q[3]) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (press_q[0]) begin
            if (sw_sync_q[9]) ir_d[15:8] = sw_sync_q[7:0];
            else              ir_d[7:0]  = sw_sync_q[7:0];
          end
          if (press_q[1]) begin
            state_d = LOAD;
            step_d  = 1'b1;
            load_d  = 1'b1;
            err_d   = 1'b0;
          end else if (press_q[2]) begin
            step_d = 1'b1;
          end
        end
        LOAD: begin
          state_d = START;
          step_d  = 1'b1;
          s_d     = 1'b1;
        end
        START: begin
          state_d   = RUN;
          step_d    = 1'b1;
          run_cnt_d = '0;
        end
        RUN: begin
          // cpu_w is still settling from the start strobe on the first step.
          run_cnt_d = run_cnt_nxt;
          if (cpu_w && run_cnt_q != '0) begin
            state_d = IDLE;
          end else if (run_cnt_nxt == RUN_LIMIT) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            step_d = 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta_q   <= '1;
      key_sync_q   <= '1;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      key_stable_q <= '1;
      db_cnt_q     <= '0;
      press_q      <= '0;
      ir_q         <= '0;
      state_q      <= IDLE;
      step_q       <= 1'b0;
      load_q       <= 1'b0;
      s_q          <= 1'b0;
      run_cnt_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      key_meta_q   <= key_n;
      key_sync_q   <= key_meta_q;
      sw_meta_q    <= sw;
      sw_sync_q    <= sw_meta_q;
      key_stable_q <= key_stable_d;
      db_cnt_q     <= db_cnt_d;
      press_q      <= press_d;
      ir_q         <= ir_d;
      state_q      <= state_d;
      step_q       <= step_d;
      load_q       <= load_d;
      s_q          <= s_d;
      run_cnt_q    <= run_cnt_d;
      err_q        <= err_d;
    end
  end

  assign ir       = ir_q;
  assign ir_view  = sw_sync_q[9] ? ir_q[7:0] : ir_q[15:8];
  assign cpu_step = step_q;
  assign cpu_load = load_q;
  assign cpu_s    = s_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_cpu_input_sequencer.sv
// Self-checking bench for cpu_input_sequencer: expected step strobes are queued
// as stimulus is driven and compared whenever the DUT issues cpu_step.
module tb_cpu_input_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_n;
  logic [9:0]  sw;
  logic [15:0] ir;
  logic [7:0]  ir_view;
  logic        cpu_step, cpu_load, cpu_s, cpu_w, busy, err;

  typedef struct packed {
    logic        load;
    logic        s;
    logic [15:0] ir;
  } strobe_t;

  strobe_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int run_seen;
  int w_after;
  bit w_en;
  logic cur_step, step_before;

  cpu_input_sequencer #(.DB_CYCLES(4), .TIMEOUT(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .key_n    (key_n),
    .sw       (sw),
    .ir       (ir),
    .ir_view  (ir_view),
    .cpu_step (cpu_step),
    .cpu_load (cpu_load),
    .cpu_s    (cpu_s),
    .cpu_w    (cpu_w),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Advance one cycle, sample at the falling edge, model cpu_w, score strobes.
  task automatic tick();
    strobe_t e;
    @(posedge clk);
    @(negedge clk);
    step_before = cur_step;
    cur_step    = cpu_step;
    if (cpu_step === 1'b1) begin
      if (busy && !cpu_load && !cpu_s) begin
        run_seen++;
        cpu_w = w_en && (run_seen > w_after);
      end else begin
        cpu_w = 1'b0;
      end
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_step: got load=%0b s=%0b ir=%h, expected no step",
                 cpu_load, cpu_s, ir);
      end else begin
        e = exp_q.pop_front();
        if ({cpu_load, cpu_s, ir} !== {e.load, e.s, e.ir}) begin
          n_fail++;
          $display("FAIL step_strobe: got load=%0b s=%0b ir=%h, expected load=%0b s=%0b ir=%h",
                   cpu_load, cpu_s, ir, e.load, e.s, e.ir);
        end
      end
    end else begin
      cpu_w = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_seq(input logic [15:0] e_ir, input int run_steps);
    exp_q.push_back('{load: 1'b1, s: 1'b0, ir: e_ir});
    exp_q.push_back('{load: 1'b0, s: 1'b1, ir: e_ir});
    for (int i = 0; i < run_steps; i++) exp_q.push_back('{load: 1'b0, s: 1'b0, ir: e_ir});
  endtask

  task automatic press_keys(input logic [3:0] mask);
    key_n = key_n & ~mask;
    ticks(8);
    key_n = key_n | mask;
  endtask

  // Busy must fall on the cycle right after the final step.
  task automatic run_until_idle(input int budget);
    int c = 0;
    while (busy === 1'b1 && c < budget) begin
      tick();
      c++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, expected 0", busy, c);
    end
    n_tests++;
    if (cpu_step !== 1'b0 || step_before !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_drop: step_now=%0b step_before=%0b, expected 0 and 1",
               cpu_step, step_before);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; key_n = 4'hF; sw = '0; cpu_w = 1'b0;
    w_en = 1'b0; w_after = 0; run_seen = 0; cur_step = 1'b0; step_before = 1'b0;
    ticks(3);
    n_tests++;
    if ({ir, ir_view, cpu_step, cpu_load, cpu_s, busy, err} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_state: ir=%h view=%h step=%0b load=%0b s=%0b busy=%0b err=%0b, expected all 0",
               ir, ir_view, cpu_step, cpu_load, cpu_s, busy, err);
    end
    reset = 1'b0;
    ticks(3);
  endtask

  task automatic test_capture();
    sw = 10'h2A5;
    ticks(3);
    key_n[0] = 1'b0; ticks(6); key_n[0] = 1'b1; ticks(10);
    n_tests++;
    if (ir !== 16'hA500 || ir_view !== 8'h00) begin
      n_fail++;
      $display("FAIL capture_hi: ir=%h view=%h, expected ir=a500 view=00", ir, ir_view);
    end
    sw = 10'h03C;
    ticks(3);
    key_n[0] = 1'b0; ticks(6); key_n[0] = 1'b1; ticks(10);
    n_tests++;
    if (ir !== 16'hA53C || ir_view !== 8'hA5) begin
      n_fail++;
      $display("FAIL capture_lo: ir=%h view=%h, expected ir=a53c view=a5", ir, ir_view);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 5; i++) begin
      key_n[1] = 1'b0; ticks(2);
      key_n[1] = 1'b1; ticks(2);
    end
    n_tests++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bounce_no_go: busy=%0b pending=%0d, expected 0 and 0", busy, exp_q.size());
    end
    w_en = 1'b1; w_after = 0; run_seen = 0;
    expect_seq(16'hA53C, 2);
    press_keys(4'b0010);
    run_until_idle(40);
    n_tests++;
    if (exp_q.size() != 0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_go: pending=%0d err=%0b, expected 0 and 0", exp_q.size(), err);
    end
    ticks(8);
  endtask

  task automatic test_timeout();
    w_en = 1'b0; run_seen = 0;
    expect_seq(16'hA53C, 8);
    press_keys(4'b0010);
    run_until_idle(40);
    n_tests++;
    if (err !== 1'b1 || exp_q.size() != 0 || run_seen != 8) begin
      n_fail++;
      $display("FAIL timeout: err=%0b pending=%0d run_steps=%0d, expected 1, 0, 8",
               err, exp_q.size(), run_seen);
    end
    ticks(8);
  endtask

  task automatic test_go_wait();
    w_en = 1'b1; w_after = 3; run_seen = 0;
    expect_seq(16'hA53C, 4);
    press_keys(4'b0010);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%0b, expected 0", err);
    end
    run_until_idle(40);
    n_tests++;
    if (err !== 1'b0 || exp_q.size() != 0 || run_seen != 4) begin
      n_fail++;
      $display("FAIL go_wait: err=%0b pending=%0d run_steps=%0d, expected 0, 0, 4",
               err, exp_q.size(), run_seen);
    end
    ticks(8);
  endtask

  task automatic test_manual_step();
    exp_q.push_back('{load: 1'b0, s: 1'b0, ir: 16'hA53C});
    press_keys(4'b0100);
    ticks(8);
    n_tests++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_step: pending=%0d busy=%0b, expected 0 and 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_capture_with_go();
    sw = 10'h255;
    ticks(3);
    w_en = 1'b1; w_after = 0; run_seen = 0;
    expect_seq(16'h553C, 2);
    press_keys(4'b0011);
    run_until_idle(40);
    n_tests++;
    if (ir !== 16'h553C || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL capture_go: ir=%h pending=%0d, expected 553c and 0", ir, exp_q.size());
    end
    ticks(8);
  endtask

  task automatic test_abort();
    sw = 10'h0FF;
    ticks(3);
    w_en = 1'b0; run_seen = 0;
    expect_seq(16'h553C, 3);
    key_n[1] = 1'b0;
    ticks(5);
    key_n[3] = 1'b0; key_n[0] = 1'b0;
    ticks(3);
    key_n[1] = 1'b1;
    ticks(5);
    key_n[3] = 1'b1; key_n[0] = 1'b1;
    n_tests++;
    if (busy !== 1'b0 || cpu_step !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stop: busy=%0b step=%0b, expected 0 and 0", busy, cpu_step);
    end
    ticks(10);
    n_tests++;
    if (exp_q.size() != 0 || ir !== 16'h553C || err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: pending=%0d ir=%h err=%0b, expected 0, 553c, 0",
               exp_q.size(), ir, err);
    end
  endtask

  task automatic test_reset_in_start();
    expect_seq(16'h553C, 0);
    key_n[1] = 1'b0;
    ticks(8);
    n_tests++;
    if (cpu_s !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_reached: s=%0b busy=%0b, expected 1 and 1", cpu_s, busy);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (cpu_s !== 1'b0 || cpu_step !== 1'b0 || busy !== 1'b0 || ir !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_async: s=%0b step=%0b busy=%0b ir=%h, expected 0, 0, 0, 0000",
               cpu_s, cpu_step, busy, ir);
    end
    key_n = 4'hF;
    ticks(3);
    reset = 1'b0;
    ticks(12);
    n_tests++;
    if (exp_q.size() != 0 || ir !== 16'h0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: pending=%0d ir=%h busy=%0b, expected 0, 0000, 0",
               exp_q.size(), ir, busy);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_bounce();
    test_timeout();
    test_go_wait();
    test_manual_step();
    test_capture_with_go();
    test_abort();
    test_reset_in_start();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
